// File: rtl/vec_ex_wb_stage.sv
// Execute-to-writeback stage: valid/ready handshake over a 2-entry (main + skid) buffer, with flush and per-lane masking.
// Optional statistics counters are built when VEC_EXWB_STATS_EN is defined.
module vec_ex_wb_stage #(
    parameter int N     = 32,
    parameter int LANES = 16,
    parameter int RA_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   alu_result,
    input  logic [LANES*N-1:0]   write_data,
    input  logic [LANES-1:0]     lane_mask,
    input  logic [RA_W-1:0]      wa3,
    input  logic                 reg_write,
    input  logic                 mem_to_reg,
    input  logic                 mem_write,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   alu_result_w,
    output logic [LANES*N-1:0]   write_data_w,
    output logic [LANES-1:0]     lane_mask_w,
    output logic [RA_W-1:0]      wa3_w,
    output logic                 reg_write_w,
    output logic                 mem_to_reg_w,
    output logic                 mem_write_w,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          xfer_cnt
);

    typedef struct packed {
        logic [LANES*N-1:0] alu;
        logic [LANES*N-1:0] wd;
        logic [LANES-1:0]   mask;
        logic [RA_W-1:0]    wa3;
        logic               rw;
        logic               m2r;
        logic               mw;
    } entry_t;

    // Encoding is {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, in_entry;
    logic   in_fire, out_fire;

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        in_entry      = '0;
        in_entry.mask = lane_mask;
        in_entry.wa3  = wa3;
        in_entry.rw   = reg_write;
        in_entry.m2r  = mem_to_reg;
        in_entry.mw   = mem_write;
        for (int i = 0; i < LANES; i++) begin
            in_entry.alu[i*N +: N] = lane_mask[i] ? alu_result[i*N +: N] : '0;
            in_entry.wd[i*N +: N]  = lane_mask[i] ? write_data[i*N +: N] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Data is left in place; out_valid=0 masks the controls.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign alu_result_w = main_q.alu;
    assign write_data_w = main_q.wd;
    assign lane_mask_w  = main_q.mask;
    assign wa3_w        = main_q.wa3;
    assign reg_write_w  = main_q.rw  & out_valid;
    assign mem_to_reg_w = main_q.m2r & out_valid;
    assign mem_write_w  = main_q.mw  & out_valid;

`ifdef VEC_EXWB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, xfer_cnt_q, xfer_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (out_fire && xfer_cnt_q != 32'hFFFF_FFFF)
            xfer_cnt_d = xfer_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign xfer_cnt  = xfer_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign xfer_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_vec_ex_wb_stage.sv
// Bench for vec_ex_wb_stage: directed steps plus random traffic checked against a 2-deep FIFO model.
module tb_vec_ex_wb_stage;
  localparam int N = 32;
  localparam int LANES = 16;
  localparam int RA_W = 4;
  localparam int DW = LANES * N;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] alu_result, write_data, alu_result_w, write_data_w;
  logic [LANES-1:0] lane_mask, lane_mask_w;
  logic [RA_W-1:0] wa3, wa3_w;
  logic reg_write, mem_to_reg, mem_write, reg_write_w, mem_to_reg_w, mem_write_w;
  logic [31:0] stall_cnt, xfer_cnt;

  vec_ex_wb_stage #(.N(N), .LANES(LANES), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .write_data(write_data), .lane_mask(lane_mask), .wa3(wa3),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_w(alu_result_w), .write_data_w(write_data_w), .lane_mask_w(lane_mask_w),
    .wa3_w(wa3_w), .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
    .mem_write_w(mem_write_w), .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [LANES-1:0] mask;
    logic [RA_W-1:0] wa3;
    logic rw;
    logic m2r;
    logic mw;
  } ent_t;

  ent_t mq[$];
  ent_t shown;
  int unsigned stall_m, xfer_m;
  int n_vec, n_fail;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic v;
    v = (mq.size() > 0);
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("alu_result_w", alu_result_w, shown.alu);
    chk("write_data_w", write_data_w, shown.wd);
    chk("lane_mask_w", lane_mask_w, shown.mask);
    chk("wa3_w", wa3_w, shown.wa3);
    chk("reg_write_w", reg_write_w, shown.rw & v);
    chk("mem_to_reg_w", mem_to_reg_w, shown.m2r & v);
    chk("mem_write_w", mem_write_w, shown.mw & v);
`ifdef VEC_EXWB_STATS_EN
    chk("stall_cnt", stall_cnt, stall_m);
    chk("xfer_cnt", xfer_cnt, xfer_m);
`else
    chk("stall_cnt", stall_cnt, 0);
    chk("xfer_cnt", xfer_cnt, 0);
`endif
  endtask

  // One clock: predict from the inputs held before the edge, then compare #1 after it.
  task automatic cycle();
    ent_t cap;
    bit do_in, do_out;
    cap = '0;
    cap.mask = lane_mask;
    cap.wa3 = wa3;
    cap.rw = reg_write;
    cap.m2r = mem_to_reg;
    cap.mw = mem_write;
    for (int i = 0; i < LANES; i++) begin
      cap.alu[i*N +: N] = lane_mask[i] ? alu_result[i*N +: N] : '0;
      cap.wd[i*N +: N] = lane_mask[i] ? write_data[i*N +: N] : '0;
    end
    do_out = (mq.size() > 0) && out_ready;
    do_in = in_valid && (mq.size() < 2);
    if (mq.size() > 0 && !out_ready) stall_m++;
    if (do_out) xfer_m++;
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      shown = '0;
      stall_m = 0;
      xfer_m = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (do_out) void'(mq.pop_front());
      if (do_in) mq.push_back(cap);
    end
    if (mq.size() > 0) shown = mq[0];
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [RA_W-1:0] w, input logic [LANES-1:0] m, input bit rnd);
    in_valid = v;
    wa3 = w;
    lane_mask = m;
    reg_write = rnd ? 1'($urandom) : 1'b1;
    mem_to_reg = rnd ? 1'($urandom) : 1'b0;
    mem_write = rnd ? 1'($urandom) : 1'b1;
    for (int i = 0; i < LANES; i++) begin
      alu_result[i*N +: N] = rnd ? 32'($urandom) : 32'(i + 1);
      write_data[i*N +: N] = rnd ? 32'($urandom) : 32'(32'h100 + i);
    end
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    stall_m = 0;
    xfer_m = 0;
    shown = '0;
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    // Reset values
    cycle();
    cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu", alu_result_w, 0);
    reset = 1'b0;
    cycle();

    // Streaming with mask
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, RA_W'(k), 16'h00FF, 1'b0);
      cycle();
      chk("stream_wa3", wa3_w, k);
      chk("stream_lane0", alu_result_w[0 +: N], 1);
      chk("stream_lane7", alu_result_w[7*N +: N], 8);
      chk("stream_lane8", alu_result_w[8*N +: N], 0);
      chk("stream_lane15", alu_result_w[15*N +: N], 0);
    end
    drive(1'b0, '0, 16'h00FF, 1'b0);
    cycle();

    // Stall and skid
    out_ready = 1'b0;
    drive(1'b1, 4'd5, 16'hFFFF, 1'b0);
    cycle();
    drive(1'b1, 4'd6, 16'hFFFF, 1'b0);
    cycle();
    chk("skid_in_ready", in_ready, 0);
    chk("skid_hold_wa3", wa3_w, 5);
    drive(1'b0, '0, 16'hFFFF, 1'b0);
    cycle();
    chk("skid_hold_wa3_2", wa3_w, 5);
    out_ready = 1'b1;
    cycle();
    chk("drain_wa3", wa3_w, 6);
    chk("drain_in_ready", in_ready, 1);
    cycle();
    chk("drain_empty", out_valid, 0);

    // Flush in FULL with simultaneous in_valid
    out_ready = 1'b0;
    drive(1'b1, 4'd7, 16'hFFFF, 1'b0);
    cycle();
    drive(1'b1, 4'd8, 16'hFFFF, 1'b0);
    cycle();
    drive(1'b1, 4'd9, 16'hFFFF, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, 16'hFFFF, 1'b0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_reg_write", reg_write_w, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cycle();
    cycle();

    // Reset mid-stall
    out_ready = 1'b0;
    drive(1'b1, 4'd10, 16'hFFFF, 1'b0);
    cycle();
    drive(1'b1, 4'd11, 16'hFFFF, 1'b0);
    cycle();
    drive(1'b0, '0, 16'hFFFF, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_mid_wa3", wa3_w, 0);
    chk("rst_mid_mask", lane_mask_w, 0);
    out_ready = 1'b1;
    cycle();
    chk("rst_mid_no_stale", out_valid, 0);

    // Counters: 3 stall cycles then 2 transfers from a fresh reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 16'hFFFF, 1'b0);
    cycle();
    drive(1'b1, 4'd2, 16'hFFFF, 1'b0);
    cycle();
    drive(1'b0, '0, 16'hFFFF, 1'b0);
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    out_ready = 1'b0;
    cycle();
`ifdef VEC_EXWB_STATS_EN
    chk("cnt_stall", stall_cnt, 3);
    chk("cnt_xfer", xfer_cnt, 2);
`else
    chk("cnt_stall_off", stall_cnt, 0);
    chk("cnt_xfer_off", xfer_cnt, 0);
`endif

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      drive(1'($urandom_range(0, 3) != 0), RA_W'($urandom), LANES'($urandom), 1'b1);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
